// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioning path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

    // Per-button debounce FSM states.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,   // stable released
        ARM_PRESS   = 2'd1,   // counting a candidate press
        HELD        = 2'd2,   // stable pressed
        ARM_RELEASE = 2'd3    // counting a candidate release
    } btn_state_t;

    // Width of the stability counter. It only needs to reach cycles-1.
    // Clamped to 1 bit so a degenerate parameter still elaborates.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_core.sv
// Single-button conditioner: 2-flop synchronizer, polarity fix, debounce FSM.
// Latency: raw level held from capture edge 0 is reported after edge DEBOUNCE_CYCLES+2.
// Backpressure: none; free-running, outputs are registered levels and 1-cycle pulses.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_raw      raw pin, asynchronous to clk
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle pulse on an accepted press
//   btn_release  one-cycle pulse on an accepted release
module debounce_core
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Pin level of a released button; also what the synchronizer resets to.
    localparam logic          INACTIVE = (ACTIVE_LOW != 0);

    logic          sync1;
    logic          sync2;
    logic          pressed;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    // Strip the board polarity so everything past here is active-high.
    assign pressed = sync2 ^ INACTIVE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= INACTIVE;
            sync2       <= INACTIVE;
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;

            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= ARM_PRESS;
                        cnt   <= '0;
                    end
                end
                ARM_PRESS: begin
                    // A single disagreeing sample abandons the candidate press.
                    if (!pressed) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HELD;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state <= ARM_RELEASE;
                        cnt   <= '0;
                    end
                end
                ARM_RELEASE: begin
                    // Level stays high while a release is only a candidate.
                    if (pressed) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Board push-button input stage: NUM_BTNS independent debounce_core lanes.
// Latency: DEBOUNCE_CYCLES+2 edges from raw capture to level/pulse, per lane.
// Backpressure: none; outputs are free-running registered levels and pulses.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_raw      raw button pins, asynchronous to clk
//   btn_level    debounced levels, 1 = pressed
//   btn_press    one-cycle pulse per accepted press
//   btn_release  one-cycle pulse per accepted release
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        debounce_core #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_core (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Upstream input stage for the board's push-buttons: takes raw, asynchronous, bouncing button pins and produces clean, synchronous, debounced levels plus single-cycle press and release pulses. It sits between the board pins and the counter/shifter logic in the top level. It also absorbs the active-low button polarity, so downstream blocks only see active-high signals.

## Interface
- NUM_BTNS, 4, number of independent buttons conditioned
- DEBOUNCE_CYCLES, 500_000, consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz); legal range ≥ 2
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed
- clk  input  1  system clock; the block's only clock
- rst  input  1  reset, asynchronous, active-high
- btn_raw  input  NUM_BTNS  raw button pins, asynchronous to clk
- btn_level  output  NUM_BTNS  debounced level, 1 = pressed
- btn_press  output  NUM_BTNS  one-cycle pulse on an accepted press
- btn_release  output  NUM_BTNS  one-cycle pulse on an accepted release

## Operation
- Each bit is processed independently and identically; there is no interaction between bits.
- Synchronizer: 2-flop chain per bit. On reset, both flops load the inactive pin level (ACTIVE_LOW ? 1 : 0).
- Normalization: pressed = sync_out XOR ACTIVE_LOW.
- Per-bit FSM, 4 states:
  - IDLE: stable released. If pressed: go to ARM_PRESS and clear the counter.
  - ARM_PRESS: if not pressed, go to IDLE. Else if cnt == DEBOUNCE_CYCLES-1, go to HELD and assert btn_press. Else cnt++.
  - HELD: stable pressed. If not pressed: go to ARM_RELEASE and clear the counter.
  - ARM_RELEASE: if pressed, go to HELD. Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE and assert btn_release. Else cnt++.
- Any sample mismatch during an ARM state aborts the arming. The FSM returns to the prior stable state, produces no pulse, and the counter restarts on the next arm.
- btn_level is 1 exactly in HELD and ARM_RELEASE. It changes only on an accepted transition.
- Counter: unsigned, width $clog2(DEBOUNCE_CYCLES). It never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- All outputs are registered; there are no combinational paths from btn_raw to any output.

## Timing
- Reset values:
  - all FSMs in IDLE, counters 0
  - btn_level = 0, btn_press = 0, btn_release = 0
  - synchronizer flops at the inactive level
- rst is asynchronous on assertion and takes effect in any state, including mid-arm. Deassertion is used synchronously by the top level.
- Press latency: a raw level captured at edge 0 and held produces btn_level = 1 and btn_press = 1 after edge DEBOUNCE_CYCLES+2.
  - btn_press stays high for exactly one cycle.
  - btn_level goes high in the same cycle as btn_press.
- Release latency is symmetric: btn_level = 0 and btn_release = 1 after edge DEBOUNCE_CYCLES+2 from the captured release.
- Pulses never overlap per bit: btn_press and btn_release are mutually exclusive. Between two pulses of the same kind, the opposite pulse must occur.
- Any pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.

## Structure
- Package btn_pkg:
  - typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_RELEASE} btn_state_t
  - localparam function for the counter width
- Sub-module debounce_core: one bit, containing the synchronizer, normalization, FSM, counter and the three registered outputs.
- btn_conditioner is a generate loop of NUM_BTNS debounce_core instances.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, NUM_BTNS=2, ACTIVE_LOW=1.
- Reset: btn_raw=2'b11, pulse rst -> all outputs 0. Hold btn_raw=2'b11 for 20 cycles -> outputs stay 0.
- Clean press/release:
  - btn_raw[0]=0 at edge 0 -> btn_level[0]=1 and btn_press[0]=1 after edge 6, btn_press[0]=0 after edge 7.
  - Then btn_raw[0]=1 -> btn_release[0] pulses 6 edges later and btn_level[0] falls.
- Bounce rejection: btn_raw[0] toggles 0/1 every 2 cycles for 20 cycles, then holds 0 -> exactly one btn_press[0], 6 edges after the final hold begins. No release pulse.
- Glitch: btn_raw[1]=0 for 3 cycles, then 1 -> no pulses, btn_level[1] stays 0.
- Reset mid-arm and in HELD:
  - rst asserted while ARM_PRESS cnt=2 -> outputs 0 immediately, no press pulse after deassert until a full 6-edge hold.
  - rst asserted in HELD -> btn_level drops asynchronously, with no release pulse.
- Independence: press both bits 1 cycle apart -> btn_press[1] pulses exactly 1 cycle after btn_press[0].
